// File: rtl/dma_controller.sv
// dma_controller: bus-master DMA moving a fixed-size block of device words into data memory
// Ports: clk, reset (async, active-high); cmd_valid/cmd_addr/cmd_ready start a transfer;
// BR/BG bus request/grant with the CPU; dev_data/dev_valid/dev_ready device word stream;
// mem_addr/mem_data/mem_write/mem_ack memory write port; dma_state word index,
// interrupt one-cycle completion pulse, busy high outside IDLE.
module dma_controller #(
  parameter int WORD_SIZE = 16,
  parameter int BLOCK_WORDS = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  output logic                 cmd_ready,
  output logic                 BR,
  input  logic                 BG,
  input  logic [WORD_SIZE-1:0] dev_data,
  input  logic                 dev_valid,
  output logic                 dev_ready,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_data,
  output logic                 mem_write,
  input  logic                 mem_ack,
  output logic [3:0]           dma_state,
  output logic                 interrupt,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
  localparam logic [3:0] LAST = 4'(BLOCK_WORDS - 1);
  state_t state, state_nx;
  logic [3:0] idx;
  logic full;
  logic [WORD_SIZE-1:0] word, base;
  logic last, ack_ok, take;
  assign last = idx == LAST;
  // an ack only counts while we actually drive a write, so acks during a revoked grant are dropped
  assign ack_ok = state == XFER && full && BG && mem_ack;
  assign take = dev_valid && dev_ready;
  always_comb begin
    state_nx = state == IDLE ? (cmd_valid ? REQ : IDLE) :
               state == REQ  ? (BG ? XFER : REQ) :
               state == XFER ? (ack_ok && last ? DONE : XFER) : IDLE;
    cmd_ready = state == IDLE;
    busy = state != IDLE;
    BR = state == REQ || state == XFER;
    interrupt = state == DONE;
    // refill in the same cycle the pending word is acked, giving one word per cycle
    dev_ready = state == XFER && (!full || (ack_ok && !last));
    mem_write = state == XFER && full && BG;
    mem_addr = mem_write ? base + WORD_SIZE'(idx) : '0;
    mem_data = mem_write ? word : '0;
    dma_state = state == DONE ? LAST : state == XFER ? idx : 4'd0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      full <= 1'b0;
      word <= '0;
      base <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cmd_valid) begin
        base <= cmd_addr;
        idx <= '0;
        full <= 1'b0;
      end else if (ack_ok) begin
        idx <= last ? idx : idx + 4'd1;
        full <= take;
      end else if (take) begin
        full <= 1'b1;
      end
      if (take) word <= dev_data;
    end
  end
endmodule
